// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM bus master.
package sram_bus_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 8;

  localparam int unsigned DefSetupCyc  = 1;
  localparam int unsigned DefAccessCyc = 2;
  localparam int unsigned DefHoldCyc   = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StHold   = 2'd3
  } sram_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one bus phase; done flags the last cycle of the phase.
module sram_phase_timer
  import sram_bus_pkg::*;
#(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            done
);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == CntW'(1));

endmodule

// File: rtl/sram_bus_master.sv
// Turns a valid/ready request into a timed async-SRAM read or write cycle with registered strobes.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DefSetupCyc,
  parameter int unsigned ACCESS_CYC = DefAccessCyc,
  parameter int unsigned HOLD_CYC   = DefHoldCyc
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AddrW-1:0] req_addr,
  input  logic [DataW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DataW-1:0] rsp_rdata,
  output logic [AddrW-1:0] sram_addr,
  output logic [DataW-1:0] sram_data_o,
  output logic             sram_data_oe,
  input  logic [DataW-1:0] sram_data_i,
  output logic             sram_cs_n,
  output logic             sram_we_n,
  output logic             sram_oe_n
);

  localparam int unsigned CntW = $clog2(max3(SETUP_CYC, ACCESS_CYC, HOLD_CYC) + 1);

  if (SETUP_CYC == 0) begin : gen_bad_setup
    $error("SETUP_CYC must be at least 1");
  end
  if (ACCESS_CYC == 0) begin : gen_bad_access
    $error("ACCESS_CYC must be at least 1");
  end
  if (HOLD_CYC == 0) begin : gen_bad_hold
    $error("HOLD_CYC must be at least 1");
  end

  sram_state_e     state_q, state_d;
  logic            we_q;
  logic [DataW-1:0] cap_q;
  logic            accept;
  logic            phase_load;
  logic            phase_done;
  logic [CntW-1:0] phase_val;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept)     state_d = StSetup;
      StSetup:  if (phase_done) state_d = StAccess;
      StAccess: if (phase_done) state_d = StHold;
      StHold:   if (phase_done) state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // The timer is reloaded with the new phase length on every state change.
  assign phase_load = (state_d != state_q);

  always_comb begin
    phase_val = '0;
    unique case (state_d)
      StSetup:  phase_val = CntW'(SETUP_CYC);
      StAccess: phase_val = CntW'(ACCESS_CYC);
      StHold:   phase_val = CntW'(HOLD_CYC);
      default:  phase_val = '0;
    endcase
  end

  sram_phase_timer #(
    .CntW(CntW)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (phase_load),
    .load_val (phase_val),
    .done     (phase_done)
  );

  // Strobes are decoded from the next state so every SRAM pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      cap_q        <= '0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_cs_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state_q   <= state_d;
      sram_cs_n <= (state_d == StIdle);
      sram_we_n <= !((state_d == StAccess) && we_q);
      sram_oe_n <= !((state_d == StAccess) && !we_q);
      rsp_valid <= (state_q == StHold) && phase_done;

      if (accept) begin
        we_q         <= req_we;
        sram_addr    <= req_addr;
        sram_data_o  <= req_wdata;
        sram_data_oe <= req_we;
      end else if (state_d == StIdle) begin
        sram_data_oe <= 1'b0;
      end

      if ((state_q == StAccess) && phase_done && !we_q) begin
        cap_q <= sram_data_i;
      end

      if ((state_q == StHold) && phase_done && !we_q) begin
        rsp_rdata <= cap_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench: directed requests push expectations, a negedge monitor checks responses.
module tb_sram_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] sram_addr;
  logic [7:0]  sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_cs_n, sram_we_n, sram_oe_n;

  sram_bus_master dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_data_i  (sram_data_i),
    .sram_cs_n    (sram_cs_n),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n)
  );

  // Second instance with stretched timing.
  logic        r2_valid, r2_ready, r2_we;
  logic [15:0] r2_addr;
  logic [7:0]  r2_wdata;
  logic        rsp2_valid;
  logic [7:0]  rsp2_rdata;
  logic [15:0] s2_addr;
  logic [7:0]  s2_data_o;
  logic        s2_data_oe, s2_cs_n, s2_we_n, s2_oe_n;

  sram_bus_master #(
    .SETUP_CYC  (2),
    .ACCESS_CYC (3),
    .HOLD_CYC   (2)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (r2_valid),
    .req_ready    (r2_ready),
    .req_we       (r2_we),
    .req_addr     (r2_addr),
    .req_wdata    (r2_wdata),
    .rsp_valid    (rsp2_valid),
    .rsp_rdata    (rsp2_rdata),
    .sram_addr    (s2_addr),
    .sram_data_o  (s2_data_o),
    .sram_data_oe (s2_data_oe),
    .sram_data_i  (8'h00),
    .sram_cs_n    (s2_cs_n),
    .sram_we_n    (s2_we_n),
    .sram_oe_n    (s2_oe_n)
  );

  // RAM model: unwritten locations read as 0x76.
  bit [7:0] mem    [0:65535];
  bit       wr_ok  [0:65535];
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n) begin
      mem[sram_addr]   <= sram_data_o;
      wr_ok[sram_addr] <= 1'b1;
    end
  end
  assign sram_data_i = (!sram_cs_n && !sram_oe_n) ?
                       (wr_ok[sram_addr] ? mem[sram_addr] : 8'h76) : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cs_cyc;
    int         acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [7:0]  last_rd = 8'h00;
  int          cs_cnt = 0, acc_cnt = 0;
  logic        prev_cs_low = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  // Monitor: invariants every cycle, scoreboard compare on rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      cs_cnt      = 0;
      acc_cnt     = 0;
      last_rd     = 8'h00;
      prev_cs_low = 1'b0;
    end else begin
      chk("oe_we_both_active", int'(!sram_we_n && !sram_oe_n), 0);
      chk("strobe_without_cs", int'(sram_cs_n && (!sram_we_n || !sram_oe_n)), 0);
      if (sram_cs_n) chk("data_oe_idle", int'(sram_data_oe), 0);
      if (!sram_cs_n && exp_q.size() > 0) begin
        chk("data_oe_dir", int'(sram_data_oe), int'(exp_q[0].we));
        if (!sram_we_n) chk("write_data", int'(sram_data_o), int'(exp_q[0].wdata));
      end
      if (!sram_cs_n && prev_cs_low) chk("addr_stable", int'(sram_addr), int'(prev_addr));
      prev_cs_low = !sram_cs_n;
      prev_addr   = sram_addr;

      if (!sram_cs_n) cs_cnt++;
      if (!sram_we_n || !sram_oe_n) acc_cnt++;
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);

      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", cyc + 1 - a, 5);
          chk("cs_low_cycles", cs_cnt, e.cs_cyc);
          chk("strobe_cycles", acc_cnt, e.acc_cyc);
          chk("rsp_rdata", int'(rsp_rdata), int'(e.we ? last_rd : e.rdata));
          if (!e.we) last_rd = e.rdata;
        end
        cs_cnt  = 0;
        acc_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rd, output int acc_edge);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 40 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      acc_edge = -1;
    end else begin
      e.we = we; e.wdata = wdata; e.rdata = exp_rd; e.cs_cyc = 4; e.acc_cyc = 2;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      acc_edge = cyc;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int a0, a1, a2, a3;
    int st, ac, ho, lat;
    logic seen_we;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
    r2_valid = 1'b0; r2_we = 1'b0; r2_addr = 16'h0; r2_wdata = 8'h0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_cs_n", int'(sram_cs_n), 1);
    chk("rst_we_n", int'(sram_we_n), 1);
    chk("rst_oe_n", int'(sram_oe_n), 1);
    chk("rst_data_oe", int'(sram_data_oe), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_data_o", int'(sram_data_o), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst2_addr", int'(s2_addr), 0);
    chk("rst2_data_o", int'(s2_data_o), 0);
    chk("rst2_rsp_rdata", int'(rsp2_rdata), 0);
    reset = 1'b0;
    chk("idle_ready", int'(req_ready), 1);

    // Write then read back.
    issue(1'b1, 16'h1234, 8'hA5, 8'h00, a0);
    wait_drain();
    issue(1'b0, 16'h1234, 8'h00, 8'hA5, a0);
    wait_drain();

    // Unwritten location.
    issue(1'b0, 16'h8000, 8'h00, 8'h76, a0);
    wait_drain();

    // Back-to-back with request held.
    issue(1'b1, 16'h0000, 8'h11, 8'h00, a0);
    issue(1'b1, 16'h0001, 8'h22, 8'h00, a1);
    issue(1'b0, 16'h0000, 8'h00, 8'h11, a2);
    issue(1'b0, 16'h0001, 8'h00, 8'h22, a3);
    chk("b2b_spacing_1", a1 - a0, 5);
    chk("b2b_spacing_2", a2 - a1, 5);
    chk("b2b_spacing_3", a3 - a2, 5);
    wait_drain();

    // Reset during the ACCESS phase of a write.
    issue(1'b1, 16'h00FF, 8'h3C, 8'h00, a0);
    for (int i = 0; i < 20 && sram_we_n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_reached_access", int'(sram_we_n), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_cs_n", int'(sram_cs_n), 1);
    chk("abort_we_n", int'(sram_we_n), 1);
    chk("abort_oe_n", int'(sram_oe_n), 1);
    chk("abort_data_oe", int'(sram_data_oe), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_ready", int'(req_ready), 1);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    issue(1'b0, 16'h1234, 8'h00, 8'hA5, a0);
    wait_drain();

    // Stretched timing 2/3/2 on the second instance.
    chk("dut2_ready", int'(r2_ready), 1);
    r2_valid = 1'b1; r2_we = 1'b1; r2_addr = 16'h0ABC; r2_wdata = 8'h5A;
    @(posedge clk);
    #1;
    a0 = cyc;
    r2_valid = 1'b0;
    st = 0; ac = 0; ho = 0; lat = -1; seen_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp2_valid) begin
        lat = cyc + 1 - a0;
        break;
      end
      chk("dut2_oe_n", int'(s2_oe_n), 1);
      if (!s2_cs_n) begin
        chk("dut2_data_oe", int'(s2_data_oe), 1);
        chk("dut2_addr", int'(s2_addr), 16'h0ABC);
        if (!s2_we_n) begin
          ac++;
          seen_we = 1'b1;
          chk("dut2_wdata", int'(s2_data_o), 8'h5A);
        end else if (seen_we) begin
          ho++;
        end else begin
          st++;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("dut2_setup_cycles", st, 2);
    chk("dut2_access_cycles", ac, 3);
    chk("dut2_hold_cycles", ho, 2);
    chk("dut2_latency", lat, 8);
    chk("dut2_idle_data_oe", int'(s2_data_oe), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
